// File: rtl/des_ip_loader.sv
// Purpose: assembles eight plaintext bytes into a 64-bit DES block and applies the initial permutation (IP).
// Latency: out_valid_o rises on the edge after the eighth byte is accepted when the output register is free.
// Backpressure: one complete block can wait behind a stalled output; while it waits, in_ready_o is low.
//
// Bit numbering: DES numbers bits 1..64 starting from the MSB. Internally, block bit n
// is stored at vector index 64-n. On the outputs, l0_o[31] is IP bit 1 and r0_o[31] is
// IP bit 33. As a result, l0_o and r0_o read as the usual hexadecimal DES values.
module des_ip_loader #(
    parameter bit LSB_BYTE_FIRST = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clear_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] l0_o,
    output logic [31:0] r0_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] asm_q, asm_d;
    logic [31:0] l0_q, l0_d;
    logic [31:0] r0_q, r0_d;
    logic        out_valid_q, out_valid_d;

    logic        accept;
    logic        consume;
    logic        out_free;
    logic        last_byte;
    logic [2:0]  slot;
    logic [5:0]  slot_base;
    logic [63:0] asm_fill;
    logic [63:0] perm_src;
    logic [63:0] perm_blk;

    // Maps output vector index (63-g) to the source vector index of the
    // assembled block. The output holds IP bit g+1, at row r and column c.
    // Rows 1..4 take the even assembled bits and rows 5..8 take the odd ones.
    // Within each row, the column walks from byte 8 back to byte 1.
    function automatic int ip_src_idx(input int g);
        int r;
        int c;
        int src;
        r = g / 8 + 1;
        c = g % 8 + 1;
        if (r <= 4) begin
            src = 8 * (8 - c) + 2 * r;
        end else begin
            src = 8 * (8 - c) + 2 * (r - 4) - 1;
        end
        return 64 - src;
    endfunction

    // The permutation is pure wiring. Each output bit selects one fixed input bit.
    for (genvar g = 0; g < 64; g++) begin : g_ip
        localparam int SRC = ip_src_idx(g);
        assign perm_blk[63 - g] = perm_src[SRC];
    end

    assign in_ready_o  = (state_q == COLLECT);
    assign out_valid_o = out_valid_q;
    assign l0_o        = l0_q;
    assign r0_o        = r0_q;

    // Byte steering and handshake decode. asm_fill is the assembly register
    // with the incoming byte already placed in its slot. This lets the eighth
    // byte be permuted in the same edge that accepts it.
    always_comb begin
        slot      = LSB_BYTE_FIRST ? (3'd7 - cnt_q) : cnt_q;
        slot_base = {3'd7 - slot, 3'b000};
        asm_fill  = asm_q;
        asm_fill[slot_base +: 8] = in_data_i;
        accept    = in_valid_i && (state_q == COLLECT);
        consume   = out_valid_q && out_ready_i;
        out_free  = !out_valid_q || out_ready_i;
        last_byte = accept && (cnt_q == 3'd7);
        // A pending block is already complete in asm_q. Otherwise the block
        // being completed this cycle is permuted.
        perm_src  = (state_q == PENDING) ? asm_q : asm_fill;
    end

    // Next-state logic for the FSM, the byte counter, the assembly register and the output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        l0_d        = l0_q;
        r0_d        = r0_q;
        out_valid_d = out_valid_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    asm_d = asm_fill;
                    cnt_d = cnt_q + 3'd1;
                    if (last_byte) begin
                        if (out_free) begin
                            l0_d        = perm_blk[63:32];
                            r0_d        = perm_blk[31:0];
                            out_valid_d = 1'b1;
                        end else begin
                            // The output is still occupied, so park the full block and stop taking bytes.
                            state_d = PENDING;
                        end
                    end
                end
            end
            PENDING: begin
                if (consume) begin
                    l0_d        = perm_blk[63:32];
                    r0_d        = perm_blk[31:0];
                    out_valid_d = 1'b1;
                    state_d     = COLLECT;
                    cnt_d       = 3'd0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        // Flush wins over every handshake in the same cycle. Stale data is
        // left in place, because valid and the counter gate all later use of it.
        if (clear_i) begin
            state_d     = COLLECT;
            cnt_d       = 3'd0;
            asm_d       = asm_q;
            l0_d        = l0_q;
            r0_d        = r0_q;
            out_valid_d = 1'b0;
        end
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= COLLECT;
            cnt_q       <= 3'd0;
            asm_q       <= 64'd0;
            l0_q        <= 32'd0;
            r0_q        <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            l0_q        <= l0_d;
            r0_q        <= r0_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/des_ip_loader.md
DES_IP_LOADER -- requirements
Module: des_ip_loader

Interface
REQ-001 Parameter LSB_BYTE_FIRST, default 0: 0 = first accepted byte carries block bits 1..8; 1 = first accepted byte carries block bits 57..64.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 clear_i  input  1  synchronous flush of partial and pending blocks.
REQ-005 in_data_i  input  8  plaintext byte; in_data_i[7] is the lowest-numbered block bit of that byte.
REQ-006 in_valid_i  input  1  in_data_i valid.
REQ-007 in_ready_o  output  1  loader can accept a byte.
REQ-008 l0_o  output  [1:32]  left half after initial permutation (IP bits 1..32).
REQ-009 r0_o  output  [1:32]  right half after IP (IP bits 33..64).
REQ-010 out_valid_o  output  1  l0_o/r0_o hold a complete permuted block.
REQ-011 out_ready_i  input  1  downstream round engine accepts the block.

Function
REQ-012 A byte is accepted on a rising edge with in_valid_i=1 and in_ready_o=1; an output block is consumed on a rising edge with out_valid_o=1 and out_ready_i=1.
REQ-013 Assembly register (64 bits, numbered 1..64) plus a 3-bit byte counter (0..7); each accepted byte fills the next 8-bit slot in the order set by LSB_BYTE_FIRST; the counter wraps 7->0 on the eighth byte.
REQ-014 IP mapping: output row r (1..8), column c (1..8) = IP bit 8*(r-1)+c; for r=1..4 it takes assembled bit 8*(8-c)+2r; for r=5..8 it takes bit 8*(8-c)+2(r-4)-1 (e.g. IP bit 1 = bit 58, IP bit 33 = bit 57, IP bit 64 = bit 7).
REQ-015 The IP is applied when the completed block moves from the assembly register into the output register; l0_o/r0_o come directly from the output register, with no combinational path from in_data_i.
REQ-016 FSM states: COLLECT, PENDING; reset state COLLECT.
REQ-017 COLLECT: in_ready_o=1; on the eighth accepted byte, if the output register is empty or consumed in the same cycle, the permuted block loads into it (out_valid_o=1 next cycle) and the FSM stays in COLLECT; otherwise it goes to PENDING.
REQ-018 PENDING: in_ready_o=0 and the assembled block is held; when the output is consumed, the held block is permuted into the output register in that same edge (out_valid_o stays 1) and the FSM returns to COLLECT with counter 0.
REQ-019 Latency: out_valid_o rises on the edge after the eighth byte is accepted (1 cycle) when the output is free.
REQ-020 Throughput: with out_ready_i held at 1, one byte is accepted every cycle and one block is emitted every 8 cycles, with no bubbles.
REQ-021 While out_valid_o=1 and out_ready_i=0, l0_o, r0_o and out_valid_o are held stable.
REQ-022 clear_i=1 takes priority over all handshakes: counter=0, FSM=COLLECT, out_valid_o=0, and any bytes or block accepted in that cycle are discarded; data registers need not be zeroed.
REQ-023 in_valid_i is ignored while in_ready_o=0, and in_data_i is a don't-care when in_valid_i=0.

Reset
REQ-024 On rst_n_i low, immediately and independent of clk_i: FSM=COLLECT, counter=0, out_valid_o=0, in_ready_o=1, l0_o=0, r0_o=0, assembly register=0.
REQ-025 Reset asserted mid-block discards the partial block; the first byte accepted after reset release is byte 1 of a new block.

Verification
REQ-026 LSB_BYTE_FIRST=0, bytes 01 23 45 67 89 AB CD EF back-to-back, out_ready_i=1 -> one cycle after byte 8: out_valid_o=1, l0_o=CC00CCFF, r0_o=F0AAF0AA.
REQ-027 LSB_BYTE_FIRST=1, bytes EF CD AB 89 67 45 23 01 -> same result as REQ-026.
REQ-028 out_ready_i=0, two blocks streamed -> first block held stable, FSM enters PENDING, in_ready_o=0 after 16th byte; out_ready_i pulsed for 1 cycle -> second block appears next cycle, in_ready_o=1.
REQ-029 Single bit 58 set (byte 8 = 0x40, others 0) -> l0_o=80000000, r0_o=00000000; bit 57 set (byte 8 = 0x80) -> r0_o=80000000.
REQ-030 clear_i pulse after 5 bytes, then a full block -> output equals IP of the new block only; clear_i while out_valid_o=1 -> out_valid_o=0 next cycle.
REQ-031 rst_n_i asserted asynchronously after 3 bytes and while a block is pending -> all outputs at reset values before the next clk_i edge; the following 8-byte block is permuted correctly.
